// File: rtl/pwm_cap_pkg.sv
// -----------------------------------------------------------------------------
// pwm_cap_pkg
// Shared types and constants for the four-channel PWM duty decoder.
//   cap_state_e : per-channel measurement state (IDLE, HIGH, LOW, STUCK)
//   CNT_W       : width of the period / high-time counters
//   DUTY_W      : width of a decoded duty value
//   DUTY_MAX    : saturation value for a decoded duty
// Helpers:
//   sat_inc     : increment that sticks at all-ones instead of wrapping
//   clamp_duty  : reduce a counter value to a duty, saturating at DUTY_MAX
// -----------------------------------------------------------------------------
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } cap_state_e;

    localparam int CNT_W  = 10;
    localparam int DUTY_W = 8;

    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;

    // The counters must never wrap: a long-stuck line would otherwise alias
    // back into a plausible-looking period.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(DUTY_MAX)) ? DUTY_MAX : v[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_cap_chan.sv
// -----------------------------------------------------------------------------
// pwm_cap_chan
// One channel of the PWM duty decoder: input synchroniser, rising-edge
// detect, period / high-time counters, measurement FSM and duty register.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   pwm_line   in   raw PWM line, asynchronous to clk
//   duty       out  last published duty
//   valid      out  one-clock strobe in the cycle duty updates
//   period_err out  qualified by valid; measured period differed from PERIOD
//
// Build option:
//   PWMCAP_AVG_EN  when defined, measured publishes are the rounded mean of
//                  the previous and current measurement; otherwise raw.
// -----------------------------------------------------------------------------
module pwm_cap_chan
    import pwm_cap_pkg::*;
#(
    parameter int unsigned PERIOD      = 256,
    parameter int unsigned MARGIN      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_line,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              period_err
);

    localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STUCK_CNT  = CNT_W'(PERIOD + MARGIN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;

    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;

    cap_state_e             state_q;
    cap_state_e             state_d;

    logic                   pub_meas;
    logic                   pub_stuck;
    logic [DUTY_W-1:0]      stuck_val;
    logic [DUTY_W-1:0]      meas;
    logic [DUTY_W-1:0]      pub_val;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign meas = clamp_duty(hi_cnt);

    // Synchroniser chain plus one more register holding the synchronised
    // level of the previous cycle, so rise is a clean single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_line};
            prev_q <= s;
        end
    end

    // Both counters restart at 1 on a rise because the rise cycle itself is
    // the first clock of the new period and of its high time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            per_cnt <= sat_inc(per_cnt);
            if (s) begin
                hi_cnt <= sat_inc(hi_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and publish requests. A rise always takes priority over the
    // stuck timeout, so a period of exactly PERIOD+MARGIN still measures.
    // IDLE and STUCK only start a measurement on a rise; a measured publish
    // needs a rise from HIGH or LOW, i.e. two consecutive rises.
    always_comb begin
        state_d   = state_q;
        pub_meas  = 1'b0;
        pub_stuck = 1'b0;
        stuck_val = '0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (per_cnt == STUCK_CNT) begin
                    state_d   = STUCK;
                    pub_stuck = 1'b1;
                    stuck_val = s ? DUTY_MAX : '0;
                end
            end
            HIGH: begin
                if (rise) begin
                    pub_meas = 1'b1;
                end else if (per_cnt == STUCK_CNT) begin
                    state_d   = STUCK;
                    pub_stuck = 1'b1;
                    stuck_val = DUTY_MAX;
                end else if (!s) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    pub_meas = 1'b1;
                    state_d  = HIGH;
                end else if (per_cnt == STUCK_CNT) begin
                    state_d   = STUCK;
                    pub_stuck = 1'b1;
                    stuck_val = '0;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PWMCAP_AVG_EN
    logic [DUTY_W-1:0] prev_meas_q;
    logic              have_prev_q;
    logic [DUTY_W:0]   sum9;

    assign sum9    = {1'b0, prev_meas_q} + {1'b0, meas} + 9'd1;
    assign pub_val = have_prev_q ? sum9[DUTY_W:1] : meas;

    // History holds the raw previous measurement. A stuck publish breaks the
    // stream, so the next measured publish after it is raw again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_meas_q <= '0;
            have_prev_q <= 1'b0;
        end else if (pub_meas) begin
            prev_meas_q <= meas;
            have_prev_q <= 1'b1;
        end else if (pub_stuck) begin
            have_prev_q <= 1'b0;
        end
    end
`else
    assign pub_val = meas;
`endif

    // Output registers: counters still hold the finished period's values in
    // the rise cycle, which is why publishing is done here and not later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty       <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
        end else begin
            valid <= pub_meas | pub_stuck;
            if (pub_meas) begin
                duty       <= pub_val;
                period_err <= (per_cnt != PERIOD_CNT);
            end else if (pub_stuck) begin
                duty       <= stuck_val;
                period_err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Four-channel PWM duty decoder; receive-side counterpart of the RGBW PWM
// generator. Each channel is decoded independently by pwm_cap_chan.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   pwm_in[3:0] in   raw PWM lines, bit n is channel n
//   duty0..3    out  last decoded duty per channel
//   valid[3:0]  out  per-channel one-clock publish strobe
//   period_err  out  per-channel, qualified by valid; period != PERIOD
//
// Build option:
//   PWMCAP_AVG_EN  enables two-sample rounded averaging in every channel.
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int unsigned PERIOD      = 256,
    parameter int unsigned MARGIN      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        pwm_in,
    output logic [DUTY_W-1:0] duty0,
    output logic [DUTY_W-1:0] duty1,
    output logic [DUTY_W-1:0] duty2,
    output logic [DUTY_W-1:0] duty3,
    output logic [3:0]        valid,
    output logic [3:0]        period_err
);

    logic [DUTY_W-1:0] duty_arr [4];

    for (genvar g = 0; g < 4; g++) begin : g_chan
        pwm_cap_chan #(
            .PERIOD      (PERIOD),
            .MARGIN      (MARGIN),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .pwm_line   (pwm_in[g]),
            .duty       (duty_arr[g]),
            .valid      (valid[g]),
            .period_err (period_err[g])
        );
    end

    assign duty0 = duty_arr[0];
    assign duty1 = duty_arr[1];
    assign duty2 = duty_arr[2];
    assign duty3 = duty_arr[3];

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Self-checking bench for pwm_capture. Stimulus drives generator-style PWM
// periods and pushes the expected publish into a per-channel queue; a
// monitor forked from the same initial block pops and compares whenever a
// valid bit is seen. Honours PWMCAP_AVG_EN to select the expected values.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int PERIOD = 256;

`ifdef PWMCAP_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] duty;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pwm_in = 4'b0000;
    logic [7:0] duty0, duty1, duty2, duty3;
    logic [3:0] valid;
    logic [3:0] period_err;
    logic [7:0] duty_vec [4];

    exp_t exp_q [4][$];
    int   valid_count [4];
    int   snap [4];

    bit   have_last [4];
    int   last_high [4];
    int   last_period [4];
    bit   have_prev [4];
    int   prev_meas [4];

    int   checks = 0;
    int   fails = 0;

    pwm_capture #(
        .PERIOD      (256),
        .MARGIN      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty0      (duty0),
        .duty1      (duty1),
        .duty2      (duty2),
        .duty3      (duty3),
        .valid      (valid),
        .period_err (period_err)
    );

    assign duty_vec[0] = duty0;
    assign duty_vec[1] = duty1;
    assign duty_vec[2] = duty2;
    assign duty_vec[3] = duty3;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (valid[ch]) begin
                        valid_count[ch]++;
                        if (exp_q[ch].size() == 0) begin
                            checks++;
                            fails++;
                            $display("[TB] FAIL ch%0d unexpected valid: actual duty=%0h required=no publish at %0t",
                                     ch, duty_vec[ch], $time);
                        end else begin
                            e = exp_q[ch].pop_front();
                            check_output($sformatf("ch%0d duty", ch), int'(duty_vec[ch]), int'(e.duty));
                            check_output($sformatf("ch%0d period_err", ch), int'(period_err[ch]), int'(e.err));
                        end
                    end
                end
            end
        end
    endtask

    // Expected publish for one complete generator period.
    task automatic push_meas(input int ch, input int high, input int period);
        int   m;
        exp_t e;
        m = (high > 255) ? 255 : high;
        if (AVG && have_prev[ch]) e.duty = 8'((prev_meas[ch] + m + 1) >> 1);
        else                      e.duty = 8'(m);
        e.err = (period != PERIOD);
        prev_meas[ch] = m;
        have_prev[ch] = 1'b1;
        exp_q[ch].push_back(e);
    endtask

    task automatic push_stuck(input int ch, input logic [7:0] d);
        exp_t e;
        e.duty = d;
        e.err  = 1'b0;
        have_prev[ch] = 1'b0;
        have_last[ch] = 1'b0;
        exp_q[ch].push_back(e);
    endtask

    // One generator period: rise, `high` clocks high, rest low. The rise that
    // starts this period completes the previous one, hence the push here.
    task automatic apply_stimulus(input int ch, input int high, input int period);
        if (have_last[ch]) push_meas(ch, last_high[ch], last_period[ch]);
        @(negedge clk);
        pwm_in[ch] = 1'b1;
        repeat (high) @(negedge clk);
        pwm_in[ch] = 1'b0;
        repeat (period - high - 1) @(negedge clk);
        last_high[ch]   = high;
        last_period[ch] = period;
        have_last[ch]   = 1'b1;
    endtask

    task automatic apply_train(input int ch, input int high, input int period, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(ch, high, period);
    endtask

    // Asserts reset between clock edges and checks that outputs clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            check_output($sformatf("%s reset duty%0d", tag, ch), int'(duty_vec[ch]), 0);
            have_last[ch] = 1'b0;
            have_prev[ch] = 1'b0;
        end
        check_output($sformatf("%s reset valid", tag), int'(valid), 0);
        check_output($sformatf("%s reset period_err", tag), int'(period_err), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        for (int ch = 0; ch < 4; ch++)
            check_output($sformatf("%s ch%0d pending", tag, ch), exp_q[ch].size(), 0);
    endtask

    // After release, no line toggles: every channel must publish its stuck
    // value once, not before ~260 clocks.
    task automatic idle_window(input string tag);
        for (int ch = 0; ch < 4; ch++) snap[ch] = valid_count[ch];
        repeat (250) @(negedge clk);
        for (int ch = 0; ch < 4; ch++)
            check_output($sformatf("%s ch%0d early pulses", tag, ch), valid_count[ch] - snap[ch], 0);
        repeat (50) @(negedge clk);
        for (int ch = 0; ch < 4; ch++)
            check_output($sformatf("%s ch%0d stuck pulses", tag, ch), valid_count[ch] - snap[ch], 1);
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            valid_count[ch] = 0;
            have_last[ch]   = 1'b0;
            have_prev[ch]   = 1'b0;
        end
        fork
            monitor_loop();
        join_none

        // Reset state, then all lines held low -> one 0x00 stuck publish each.
        $display("[TB] reset and held-low idle");
        #1;
        for (int ch = 0; ch < 4; ch++)
            check_output($sformatf("power-on duty%0d", ch), int'(duty_vec[ch]), 0);
        check_output("power-on valid", int'(valid), 0);
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) push_stuck(ch, 8'h00);
        release_reset();
        idle_window("idle0");

        // Duty 0x40 stream, then 0x80 (averaging shows on the second 0x80 rise).
        $display("[TB] channel 0 duty 0x40 then 0x80");
        apply_train(0, 8'h40, 256, 4);
        apply_train(0, 8'h80, 256, 2);
        push_stuck(0, 8'h00);
        repeat (300) @(negedge clk);

        // Extremes of duty and a high time beyond 255.
        $display("[TB] duty extremes and saturation");
        apply_train(1, 255, 256, 3);
        push_stuck(1, 8'h00);
        apply_train(2, 1, 256, 3);
        push_stuck(2, 8'h00);
        apply_train(3, 258, 259, 3);
        // Off-nominal period, continuing the same stream.
        apply_train(3, 50, 200, 3);
        push_stuck(3, 8'h00);
        repeat (300) @(negedge clk);
        check_drained("train");

        // Line held high after reset -> 0xFF stuck publish, then silence.
        $display("[TB] held-high line");
        do_reset("hi");
        pwm_in[1] = 1'b1;
        push_stuck(0, 8'h00);
        push_stuck(1, 8'hFF);
        push_stuck(2, 8'h00);
        push_stuck(3, 8'h00);
        release_reset();
        idle_window("hold1");
        pwm_in[1] = 1'b0;
        for (int ch = 0; ch < 4; ch++) snap[ch] = valid_count[ch];
        repeat (300) @(negedge clk);
        for (int ch = 0; ch < 4; ch++)
            check_output($sformatf("post-stuck ch%0d pulses", ch), valid_count[ch] - snap[ch], 0);

        // Reset in the middle of a running 0x80 stream.
        $display("[TB] reset mid-stream");
        apply_train(0, 8'h80, 256, 3);
        push_meas(0, last_high[0], last_period[0]);
        @(negedge clk);
        pwm_in[0] = 1'b1;
        repeat (128) @(negedge clk);
        pwm_in[0] = 1'b0;
        repeat (40) @(negedge clk);
        check_drained("pre-reset");
        check_output("pre-reset duty0", int'(duty0), 8'h80);
        do_reset("mid");
        push_stuck(1, 8'h00);
        push_stuck(2, 8'h00);
        push_stuck(3, 8'h00);
        release_reset();
        apply_train(0, 8'h80, 256, 3);
        push_stuck(0, 8'h00);
        repeat (300) @(negedge clk);
        check_drained("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard bound so a broken DUT or bench can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: actual=not finished required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Four-channel PWM duty decoder; the receive-side counterpart of the RGBW PWM generator.
- Recovers the 8-bit duty of each incoming PWM line by counting high and period clocks between rising edges.
- Used for loopback self-test of the LED outputs and for reading an external PWM dimming input into the colour path.
- Assumes the generator's frame: period = PERIOD clocks, high time = duty clocks, with duty 0..255.

Parameters:
- PERIOD, 256, nominal PWM period in clocks; a measurement whose period differs from this is flagged.
- MARGIN, 4, extra clocks beyond PERIOD with no rising edge before a channel is declared stuck.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser per channel; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- pwm_in  input  4  raw PWM lines, asynchronous to clk; bit n is channel n.
- duty0  output  8  last decoded duty, channel 0.
- duty1  output  8  last decoded duty, channel 1.
- duty2  output  8  last decoded duty, channel 2.
- duty3  output  8  last decoded duty, channel 3.
- valid  output  4  one-clock strobe per channel; high in the cycle its duty register updates.
- period_err  output  4  qualified by valid[n]; 1 when the measured period != PERIOD.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low. While reset=0:
  - duty0..3 = 0x00, valid = 0, period_err = 0;
  - synchronisers and edge-detect registers = 0;
  - every channel FSM = IDLE, counters = 0.
- Input path: each line passes through SYNC_STAGES flops, then a previous-value register.
  - rise = s & ~prev.
  - A pwm_in rising edge first sampled at clock k gives rise in cycle k+SYNC_STAGES.
  - The publish strobe follows at k+SYNC_STAGES+1.
- Counters per channel (CNT_W = 10 bits):
  - per_cnt and hi_cnt; both saturate at all-ones and never wrap.
  - On rise: per_cnt = 1; hi_cnt = 1.
  - Otherwise: per_cnt += 1; hi_cnt += 1 only while s = 1.
- FSM per channel: IDLE, HIGH, LOW, STUCK.
  - IDLE: counts with no publish. rise -> HIGH. per_cnt == PERIOD+MARGIN -> STUCK and publish duty = s ? 0xFF : 0x00, period_err = 0.
  - HIGH: s falls -> LOW. rise (only possible after a 1-clock low) -> publish. per_cnt == PERIOD+MARGIN -> STUCK, publish 0xFF.
  - LOW: rise -> publish, then -> HIGH. per_cnt == PERIOD+MARGIN -> STUCK, publish 0x00.
  - STUCK: no further strobes. rise -> HIGH with counters restarted; this is not a publish.
- Publish (in the cycle after rise, registered):
  - dutyN = min(hi_cnt, 255); valid[n] = 1 for exactly one clock.
  - period_err[n] = (per_cnt != PERIOD).
  - The first rise after reset or STUCK only starts a measurement; a publish needs two consecutive rises.
- Simultaneous events: rise in the same cycle per_cnt reaches PERIOD+MARGIN -> the rise wins; publish, no STUCK.
- Channels are fully independent; several valid bits may assert in the same cycle.
- Reset asserted mid-measurement: everything clears immediately; partial counts are discarded.

Optional Feature:
- PWMCAP_AVG_EN defined:
  - Each publish from a rise outputs the rounded mean, (prev_meas + new_meas + 1) >> 1, using 9-bit intermediate arithmetic.
  - The first publish after reset or STUCK outputs the raw value and seeds prev_meas.
  - STUCK publishes are never averaged.
- PWMCAP_AVG_EN undefined: the raw measurement is published; no history register is built.

Decomposition:
- Package pwm_cap_pkg holds:
  - state enum {IDLE, HIGH, LOW, STUCK};
  - CNT_W = 10;
  - DUTY_W = 8;
  - saturation constant DUTY_MAX = 8'hFF.
- Sub-module pwm_cap_chan contains one channel: synchroniser, edge detect, counters, FSM, duty register and optional averaging.
- pwm_capture instantiates pwm_cap_chan four times and maps the outputs to duty0..3.

Test Plan:
- Generator waveform, duty 0x40, period 256, on channel 0 -> from the second rise onward, duty0 = 0x40 and valid[0] pulses every 256 clocks with period_err[0] = 0.
- Duty 0xFF (255 high, 1 low) and duty 0x01 (1 high, 255 low) -> duty = 0xFF and 0x01 respectively, no STUCK.
- pwm_in held 0 after reset -> a single valid pulse 260 clocks after reset release with duty = 0x00; pwm_in held 1 -> duty = 0xFF; no further pulses after either.
- Period 200, high 50 -> duty = 50 (0x32) and period_err = 1 on each publish.
- Reset pulse mid-period on a running 0x80 stream -> outputs drop to 0 asynchronously; the next valid arrives only after two post-reset rises.
- Duty 0x40 then 0x80 -> second publish shows 0x60 with PWMCAP_AVG_EN defined and 0x80 without.
